// File: rtl/div_monitor.sv
// Divided-clock monitor: measures period (and optionally high time) of i_clk_div
// sampled on i_clk_in, locks after LOCK_CNT good periods. DIV_MON_DUTY_CHECK_EN adds the duty check.
module div_monitor #(
  parameter int CNT_W     = 8,
  parameter int DIV_RATIO = 3,
  parameter int LOCK_CNT  = 4,
  parameter int HI_MIN    = 1,
  parameter int HI_MAX    = 2
) (
  input  logic             i_clk_in,
  input  logic             i_rst,
  input  logic             i_clk_div,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_err
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DIV_R   = CNT_W'(DIV_RATIO);
  localparam logic [GW-1:0]    LOCK_G  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_d1, r_d2;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_period;
  logic [GW-1:0]    r_good_cnt, w_good_nxt, w_good_inc;
  logic             r_valid, r_lock, r_err;
  logic             w_rise, w_tmo, w_good, w_meas, w_err_set;

  assign w_rise     = r_d1 & ~r_d2;
  assign w_tmo      = (r_per_cnt == CNT_MAX);
  assign w_good_inc = r_good_cnt + 1'b1;

`ifdef DIV_MON_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HI_LO = CNT_W'(HI_MIN);
  localparam logic [CNT_W-1:0] HI_HI = CNT_W'(HI_MAX);
  logic [CNT_W-1:0] r_hi_cnt, r_high;

  assign w_good = (r_per_cnt == DIV_R) && (r_hi_cnt >= HI_LO) && (r_hi_cnt <= HI_HI);
  assign o_high = r_high;

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_hi_cnt <= '0;
      r_high   <= '0;
    end else begin
      if (w_rise)
        r_hi_cnt <= CNT_W'(1);
      else if (r_d1 && r_hi_cnt != CNT_MAX)
        r_hi_cnt <= r_hi_cnt + 1'b1;
      if (w_meas)
        r_high <= r_hi_cnt;
    end
  end
`else
  assign w_good = (r_per_cnt == DIV_R);
  assign o_high = '0;
`endif

  assign o_period = r_period;
  assign o_valid  = r_valid;
  assign o_lock   = r_lock;
  assign o_err    = r_err;

  always_ff @(posedge i_clk_in) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Timeout wins over a coincident rise; the measurement itself is still reported.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_err_set   = 1'b0;
    w_meas      = 1'b0;
    case (r_state)
      S_IDLE: if (w_rise) w_state_nxt = S_ACQ;
      S_ACQ: begin
        w_meas = w_rise;
        if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_good_nxt  = '0;
        end else if (w_rise) begin
          if (w_good) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_G) w_state_nxt = S_LOCK;
          end else begin
            w_good_nxt = '0;
          end
        end
      end
      S_LOCK: begin
        w_meas = w_rise;
        if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_good_nxt  = '0;
          w_err_set   = 1'b1;
        end else if (w_rise && !w_good) begin
          w_state_nxt = S_ACQ;
          w_good_nxt  = '0;
          w_err_set   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_d1       <= 1'b0;
      r_d2       <= 1'b0;
      r_per_cnt  <= '0;
      r_good_cnt <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_d1       <= i_clk_div;
      r_d2       <= r_d1;
      r_good_cnt <= w_good_nxt;
      if (w_rise)
        r_per_cnt <= CNT_W'(1);
      else if (!w_tmo)
        r_per_cnt <= r_per_cnt + 1'b1;
      r_valid <= w_meas;
      if (w_meas)
        r_period <= r_per_cnt;
      r_lock <= (w_state_nxt == S_LOCK);
      // Set beats clear when both happen together.
      r_err  <= w_err_set | (r_err & ~i_clr);
    end
  end
endmodule

// File: tb/tb_div_monitor.sv
// Directed bench for div_monitor: per-period vector table plus hand sequences
// for clear/set collision, reset pulse, timeout and a DIV_RATIO=5 instance.
module tb_div_monitor;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_clk_div = 1'b0, i_clr = 1'b0;
  logic [7:0] o_period, o_high;
  logic       o_valid, o_lock, o_err;
  logic       rst5 = 1'b1, div5 = 1'b0;
  logic [7:0] per5, high5;
  logic       valid5, lock5, err5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_monitor dut (
    .i_clk_in(clk), .i_rst(i_rst), .i_clk_div(i_clk_div), .i_clr(i_clr),
    .o_period(o_period), .o_high(o_high), .o_valid(o_valid), .o_lock(o_lock), .o_err(o_err)
  );

  div_monitor #(.DIV_RATIO(5)) dut5 (
    .i_clk_in(clk), .i_rst(rst5), .i_clk_div(div5), .i_clr(1'b0),
    .o_period(per5), .o_high(high5), .o_valid(valid5), .o_lock(lock5), .o_err(err5)
  );

  typedef struct {
    int hi; int lo;
    int exp_v; int exp_per; int exp_high; int exp_lock; int exp_err;
  } vec_t;

  vec_t tbl [13];

  function automatic int eh(input int h);
`ifdef DIV_MON_DUTY_CHECK_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one i_clk_div period starting at a negedge; capture any o_valid seen.
  task automatic drive_period(input int hi, input int lo, output int gv, output int gp, output int gh);
    gv = 0; gp = 0; gh = 0;
    for (int i = 0; i < hi + lo; i++) begin
      i_clk_div = (i < hi);
      @(negedge clk);
      if (o_valid) begin
        gv = gv + 1; gp = int'(o_period); gh = int'(o_high);
      end
    end
  endtask

  initial begin
    int gv, gp, gh, lv, lp, lh;
    tbl[0]  = '{1, 2, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 2, 1, 3, 1, 0, 0};
    tbl[2]  = '{1, 2, 1, 3, 1, 0, 0};
    tbl[3]  = '{1, 2, 1, 3, 1, 0, 0};
    tbl[4]  = '{1, 2, 1, 3, 1, 1, 0};
    tbl[5]  = '{1, 3, 1, 3, 1, 1, 0};
    tbl[6]  = '{1, 2, 1, 4, 1, 0, 1};
    tbl[7]  = '{1, 2, 1, 3, 1, 0, 1};
    tbl[8]  = '{1, 2, 1, 3, 1, 0, 1};
    tbl[9]  = '{1, 2, 1, 3, 1, 0, 1};
    tbl[10] = '{2, 1, 1, 3, 1, 1, 1};
    tbl[11] = '{1, 2, 1, 3, 2, 1, 1};
    tbl[12] = '{1, 2, 1, 3, 1, 1, 1};

    repeat (10) @(negedge clk);
    chk("rst_period", int'(o_period), 0);
    chk("rst_high",   int'(o_high),   0);
    chk("rst_valid",  int'(o_valid),  0);
    chk("rst_lock",   int'(o_lock),   0);
    chk("rst_err",    int'(o_err),    0);
    i_rst = 1'b0;

    for (int k = 0; k < 13; k++) begin
      drive_period(tbl[k].hi, tbl[k].lo, gv, gp, gh);
      chk($sformatf("v%0d_valid", k), gv, tbl[k].exp_v);
      if (tbl[k].exp_v != 0) begin
        chk($sformatf("v%0d_period", k), gp, tbl[k].exp_per);
        chk($sformatf("v%0d_high", k), gh, eh(tbl[k].exp_high));
      end
      chk($sformatf("v%0d_lock", k), int'(o_lock), tbl[k].exp_lock);
      chk($sformatf("v%0d_err", k), int'(o_err), tbl[k].exp_err);
    end

    // Clear held while a bad period (4) sets the error: set wins, then clear alone.
    i_clk_div = 1'b0; @(negedge clk);
    i_clk_div = 1'b1; @(negedge clk);
    i_clr = 1'b1;     @(negedge clk);
    chk("clr_set_valid",  int'(o_valid),  1);
    chk("clr_set_period", int'(o_period), 4);
    chk("clr_set_err",    int'(o_err),    1);
    chk("clr_set_lock",   int'(o_lock),   0);
    i_clk_div = 1'b0; @(negedge clk);
    chk("clr_alone_err",  int'(o_err),    0);
    i_clr = 1'b0;

    for (int k = 0; k < 6; k++) drive_period(1, 2, gv, gp, gh);
    chk("relock_lock", int'(o_lock), 1);
    chk("relock_err",  int'(o_err),  0);

    // One-cycle reset pulse while locked.
    i_rst = 1'b1; @(negedge clk);
    chk("rpulse_lock",   int'(o_lock),   0);
    chk("rpulse_valid",  int'(o_valid),  0);
    chk("rpulse_period", int'(o_period), 0);
    chk("rpulse_high",   int'(o_high),   0);
    chk("rpulse_err",    int'(o_err),    0);
    i_rst = 1'b0;
    drive_period(1, 2, gv, gp, gh);
    chk("rpost_rise1_valid", gv, 0);
    drive_period(1, 2, gv, gp, gh);
    chk("rpost_rise2_valid", gv, 1);
    drive_period(1, 2, gv, gp, gh);
    chk("rpost_nolock", int'(o_lock), 0);
    drive_period(1, 2, gv, gp, gh);
    drive_period(1, 2, gv, gp, gh);
    chk("rpost_lock", int'(o_lock), 1);

    // Stuck low: counter reaches 255 two samples into the wait plus 253 more.
    i_clk_div = 1'b0;
    repeat (253) @(negedge clk);
    chk("tmo_before_lock", int'(o_lock), 1);
    @(negedge clk);
    chk("tmo_lock", int'(o_lock), 0);
    chk("tmo_err",  int'(o_err),  1);
    drive_period(1, 2, gv, gp, gh);
    chk("tmo_idle_novalid", gv, 0);

    // DIV_RATIO=5 instance with a 4-high/1-low input.
    rst5 = 1'b0;
    lv = 0; lp = 0; lh = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 5; i++) begin
        div5 = (i < 4);
        @(negedge clk);
        if (valid5) begin lv++; lp = int'(per5); lh = int'(high5); end
      end
    end
    chk("r5_valid_count", lv, 5);
    chk("r5_period", lp, 5);
    chk("r5_high", lh, eh(4));
`ifdef DIV_MON_DUTY_CHECK_EN
    chk("r5_lock", int'(lock5), 0);
`else
    chk("r5_lock", int'(lock5), 1);
`endif
    chk("r5_err", int'(err5), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
